// File: rtl/i2c_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | i2c_pkg                                                               |
// | Shared constants for the write-only I2C bit engine: register          |
// | addresses, command-register bit positions, FSM state codes and the    |
// | default quarter-period divider.                                       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package i2c_pkg;

  // Register addresses on the controller bus port
  localparam logic [2:0] c_ADR_TXR = 3'd3;
  localparam logic [2:0] c_ADR_CR  = 3'd4;

  // Command register bit positions
  localparam int c_CR_STA = 7;
  localparam int c_CR_STO = 6;
  localparam int c_CR_WR  = 4;

  // FSM state encoding
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_START = 3'd1;
  localparam logic [2:0] c_ST_BIT   = 3'd2;
  localparam logic [2:0] c_ST_ACK   = 3'd3;
  localparam logic [2:0] c_ST_STOP  = 3'd4;
  localparam logic [2:0] c_ST_DONE  = 3'd5;

  // 55 MHz clk -> ~100 kHz SCL
  localparam int c_CLK_DIV_DEFAULT = 138;

endpackage
`default_nettype wire

// File: rtl/i2c_qtick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | i2c_qtick                                                             |
// | Quarter-period divider and q0..q3 phase counter. Emits a one-clock    |
// | quarter_end strobe on the last clock of each quarter.                 |
// | Optional macro I2C_CLK_STRETCH_EN: while SCL is released and the pad  |
// | still reads low, the divider holds on its last count.                 |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module i2c_qtick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = c_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_run,
  input  logic       i_scl_rel,
  input  logic       i_scl,
  output logic       o_quarter_end,
  output logic [1:0] o_phase
);

  localparam logic [11:0] c_LAST = 12'(CLK_DIV - 1);

  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic        w_at_last;
  logic        w_stall;
  logic        w_qend;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low freezes the quarter on its final count
  assign w_stall = i_scl_rel & ~i_scl;
`else
  logic w_unused_stretch;
  assign w_unused_stretch = i_scl_rel ^ i_scl;
  assign w_stall          = 1'b0;
`endif

  assign w_at_last     = (cnt_q == c_LAST);
  assign w_qend        = i_run & w_at_last & ~w_stall;
  assign o_quarter_end = w_qend;
  assign o_phase       = phase_q;

  // Next-count logic: idle parks at q0/count 0 so a new state starts cleanly
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!i_run) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (w_qend) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else if (!w_at_last) begin
      cnt_d = cnt_q + 12'd1;
    end
  end

  // Divider and phase registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_wr_master.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | i2c_wr_master                                                         |
// | Write-only I2C bit engine. Latches TXR/CR writes from the command     |
// | controller and shifts one byte per command onto the bus, with        |
// | optional START/STOP, slave ACK check and a one-cycle done pulse.      |
// | Optional macro I2C_CLK_STRETCH_EN enables slave clock stretching.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module i2c_wr_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = c_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] iv_wb_adr,
  input  logic [7:0] iv_wb_dat,
  input  logic       i_wb_we,
  input  logic       i_wb_stb,
  input  logic       i_wb_cyc,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_ack_err,
  output logic       o_scl_oe,
  output logic       o_sda_oe,
  input  logic       i_scl,
  input  logic       i_sda
);

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] txr_q, txr_d;
  logic       sta_q, sta_d;
  logic       sto_q, sto_d;
  logic       busy_q, busy_d;
  logic       ack_err_q, ack_err_d;
  logic       hold_scl_q, hold_scl_d;

  logic       w_wr;
  logic       w_txr_wr;
  logic       w_cr_acc;
  logic       w_run;
  logic       w_qend;
  logic [1:0] w_phase;
  logic       w_state_end;
  logic       w_scl_oe;
  logic       w_sda_oe;

  assign w_wr     = i_wb_we & i_wb_stb & i_wb_cyc;
  assign w_txr_wr = w_wr & (iv_wb_adr == c_ADR_TXR) & ~busy_q;
  assign w_cr_acc = w_wr & (iv_wb_adr == c_ADR_CR) & ~busy_q & iv_wb_dat[c_CR_WR];

  assign w_run = (state_q == c_ST_START) | (state_q == c_ST_BIT) |
                 (state_q == c_ST_ACK)   | (state_q == c_ST_STOP);
  assign w_state_end = w_qend & (w_phase == 2'd3);

  i2c_qtick #(
    .CLK_DIV(CLK_DIV)
  ) u_qtick (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_run        (w_run),
    .i_scl_rel    (w_run & ~w_scl_oe),
    .i_scl        (i_scl),
    .o_quarter_end(w_qend),
    .o_phase      (w_phase)
  );

  // Command acceptance, state sequencing, bit counting and ACK check
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    txr_d      = txr_q;
    sta_d      = sta_q;
    sto_d      = sto_q;
    busy_d     = busy_q;
    ack_err_d  = ack_err_q;
    hold_scl_d = hold_scl_q;

    if (w_txr_wr) begin
      txr_d = iv_wb_dat;
    end

    if (w_cr_acc) begin
      sta_d      = iv_wb_dat[c_CR_STA];
      sto_d      = iv_wb_dat[c_CR_STO];
      ack_err_d  = 1'b0;
      busy_d     = 1'b1;
      hold_scl_d = 1'b0;
    end

    case (state_q)
      c_ST_IDLE: begin
        if (w_cr_acc) begin
          state_d   = iv_wb_dat[c_CR_STA] ? c_ST_START : c_ST_BIT;
          bit_cnt_d = 3'd0;
        end
      end
      c_ST_START: begin
        if (w_state_end) begin
          state_d   = c_ST_BIT;
          bit_cnt_d = 3'd0;
        end
      end
      c_ST_BIT: begin
        if (w_state_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = c_ST_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      c_ST_ACK: begin
        // Slave drives ACK low; a released line at the end of q2 is a NACK
        if (w_qend && (w_phase == 2'd2) && i_sda) begin
          ack_err_d = 1'b1;
        end
        if (w_state_end) begin
          state_d    = sto_q ? c_ST_STOP : c_ST_DONE;
          // Without STOP the bus stays owned: keep SCL low afterwards
          hold_scl_d = ~sto_q;
        end
      end
      c_ST_STOP: begin
        if (w_state_end) begin
          state_d = c_ST_DONE;
        end
      end
      c_ST_DONE: begin
        state_d = c_ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = c_ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Bus drive decode from state and quarter phase
  always_comb begin
    w_scl_oe = 1'b0;
    w_sda_oe = 1'b0;
    case (state_q)
      c_ST_START: begin
        w_sda_oe = (w_phase == 2'd2) | (w_phase == 2'd3);
        w_scl_oe = (w_phase == 2'd3);
      end
      c_ST_BIT: begin
        w_scl_oe = (w_phase == 2'd0) | (w_phase == 2'd3);
        w_sda_oe = ~txr_q[3'd7 - bit_cnt_q];
      end
      c_ST_ACK: begin
        w_scl_oe = (w_phase == 2'd0) | (w_phase == 2'd3);
      end
      c_ST_STOP: begin
        w_scl_oe = (w_phase == 2'd0);
        w_sda_oe = (w_phase == 2'd0) | (w_phase == 2'd1);
      end
      default: begin
        w_scl_oe = hold_scl_q;
      end
    endcase
  end

  // Engine registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= c_ST_IDLE;
      bit_cnt_q  <= 3'd0;
      txr_q      <= 8'd0;
      sta_q      <= 1'b0;
      sto_q      <= 1'b0;
      busy_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      hold_scl_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      txr_q      <= txr_d;
      sta_q      <= sta_d;
      sto_q      <= sto_d;
      busy_q     <= busy_d;
      ack_err_q  <= ack_err_d;
      hold_scl_q <= hold_scl_d;
    end
  end

  assign o_done    = (state_q == c_ST_DONE);
  assign o_busy    = busy_q;
  assign o_ack_err = ack_err_q;
  assign o_scl_oe  = w_scl_oe;
  assign o_sda_oe  = w_sda_oe;

endmodule
`default_nettype wire
